// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR pattern generator and its receive-side checker.
// Polynomial x^4+x^3+1, period 15; the all-zero word is never produced.
package lfsr_pkg;

  localparam int LFSR_W = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] w);
    return {w[2:0], w[3] ^ w[2]};
  endfunction

endpackage

// File: rtl/lfsr_next_step.sv
// Combinational next-word step of the 4-bit LFSR sequence.
module lfsr_next_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt
);

  assign nxt = lfsr_next(cur);

endmodule

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for the 4-bit LFSR word stream: hunts, confirms, then
// flywheels the prediction while locked and counts mismatches.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_CNT   = 3,
  parameter int MISS_LIMIT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] pred,
  output logic [1:0]       fsm_state
);

  // Stream handshake: valid-only, no backpressure. A word is consumed on every rising
  // edge where in_valid=1; with in_valid=0 all state holds and err_pulse drops to 0.

  localparam int MCW = $clog2(LOCK_CNT + 1);
  localparam int MSW = $clog2(MISS_LIMIT + 1);
  localparam logic [MCW-1:0] LOCK_TGT = MCW'(LOCK_CNT);
  localparam logic [MSW-1:0] MISS_TGT = MSW'(MISS_LIMIT);

  state_t           state, state_d;
  logic [WIDTH-1:0] pred_d;
  logic [MCW-1:0]   match_cnt, match_d, match_inc;
  logic [MSW-1:0]   miss_cnt, miss_d, miss_inc;
  logic             locked_d;
  logic             pulse_d;
  logic [CNT_W-1:0] count_d;
  logic [WIDTH-1:0] data_adv;
  logic [WIDTH-1:0] pred_adv;

  lfsr_next_step u_data_step (
    .cur (in_data),
    .nxt (data_adv)
  );

  lfsr_next_step u_pred_step (
    .cur (pred),
    .nxt (pred_adv)
  );

  assign match_inc = match_cnt + 1'b1;
  assign miss_inc  = miss_cnt + 1'b1;
  assign fsm_state = state;

  always_comb begin
    state_d  = state;
    pred_d   = pred;
    match_d  = match_cnt;
    miss_d   = miss_cnt;
    locked_d = locked;
    pulse_d  = 1'b0;
    count_d  = err_count;

    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_data != '0) begin
            pred_d  = data_adv;
            match_d = '0;
            state_d = SYNC;
          end
        end

        SYNC: begin
          if (in_data == pred) begin
            match_d = match_inc;
            pred_d  = data_adv;
            if (match_inc == LOCK_TGT) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end else if (in_data != '0) begin
            pred_d  = data_adv;
            match_d = '0;
          end else begin
            state_d = HUNT;
          end
        end

        LOCKED: begin
          // Flywheel: prediction follows the sequence, never the received data.
          pred_d = pred_adv;
          if (in_data == pred) begin
            miss_d = '0;
          end else begin
            pulse_d = 1'b1;
            if (err_count != '1) count_d = err_count + 1'b1;
            if (miss_inc == MISS_TGT) begin
              state_d  = HUNT;
              locked_d = 1'b0;
              miss_d   = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end

        default: begin
          state_d  = HUNT;
          locked_d = 1'b0;
        end
      endcase
    end

    // Clear wins over a same-cycle increment; it never touches lock state.
    if (clr) count_d = '0;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= HUNT;
      pred      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_d;
      pred      <= pred_d;
      match_cnt <= match_d;
      miss_cnt  <= miss_d;
      locked    <= locked_d;
      err_pulse <= pulse_d;
      err_count <= count_d;
    end
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Self-checking bench for lfsr_seq_checker: directed scenarios plus a randomized run
// against a table-driven reference model.
module tb_lfsr_seq_checker;

  localparam int LOCK_CNT   = 3;
  localparam int MISS_LIMIT = 4;
  localparam int CNT_MAX    = 65535;

  logic        clk;
  logic        res_n;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        clr;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [3:0]  pred;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [3:0] seq_tab [15];
  int         m_mode;     // 0 hunting, 1 confirming, 2 locked
  int         m_match;
  int         m_miss;
  logic [3:0] m_pred;
  int         m_errs;
  bit         m_pulse;
  logic [3:0] exp_q [$];

  lfsr_seq_checker #(
    .WIDTH      (4),
    .LOCK_CNT   (LOCK_CNT),
    .MISS_LIMIT (MISS_LIMIT),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .res_n     (res_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr       (clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .pred      (pred),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_next(input logic [3:0] w);
    for (int i = 0; i < 15; i++)
      if (seq_tab[i] == w) return seq_tab[(i + 1) % 15];
    return 4'd0;
  endfunction

  task automatic build_table();
    int v;
    v = 15;
    for (int i = 0; i < 15; i++) begin
      seq_tab[i] = v[3:0];
      v = ((v * 2) % 16) + (((v / 8) + (v / 4)) % 2);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_match = 0; m_miss = 0; m_pred = 4'd0; m_errs = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit v, input logic [3:0] d, input bit c);
    m_pulse = 0;
    if (v) begin
      if (m_mode == 0) begin
        if (d != 0) begin m_pred = ref_next(d); m_match = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (d == m_pred) begin
          m_match++;
          m_pred = ref_next(d);
          if (m_match == LOCK_CNT) begin m_mode = 2; m_miss = 0; end
        end else if (d != 0) begin
          m_pred = ref_next(d); m_match = 0;
        end else begin
          m_mode = 0;
        end
      end else begin
        if (d != m_pred) begin
          m_pulse = 1;
          if (m_errs < CNT_MAX) m_errs++;
          m_miss++;
          if (m_miss == MISS_LIMIT) begin m_mode = 0; m_miss = 0; end
        end else begin
          m_miss = 0;
        end
        m_pred = ref_next(m_pred);
      end
    end
    if (c) m_errs = 0;
  endtask

  // driver: apply one cycle of input, update model, settle past the edge
  task automatic step(input bit v, input logic [3:0] d, input bit c);
    in_valid = v; in_data = d; clr = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
  endtask

  task automatic do_reset();
    res_n = 1'b0; in_valid = 1'b0; in_data = 4'd0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 res_n = 1'b1;
  endtask

  task automatic send_lock_run();
    step(1, 4'b1111, 0); step(1, 4'b1110, 0); step(1, 4'b1100, 0); step(1, 4'b1000, 0);
  endtask

  task automatic test_reset();
    send_lock_run();
    @(posedge clk);
    #3 res_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b want 0", locked); end
    n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", err_count); end
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %0b want 0", err_pulse); end
    n_checks++; if (pred !== 4'd0) begin n_fail++; $display("FAIL reset_pred: got %b want 0000", pred); end
    n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
    @(posedge clk);
    #1 res_n = 1'b1;
  endtask

  task automatic test_lock();
    step(1, 4'b1111, 0); step(1, 4'b1110, 0); step(1, 4'b1100, 0);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %0b want 0", locked); end
    step(1, 4'b1000, 0);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_locked: got %0b want 1", locked); end
    n_checks++; if (pred !== 4'b0001) begin n_fail++; $display("FAIL lock_pred: got %b want 0001", pred); end
  endtask

  task automatic test_single_error();
    step(1, 4'b0000, 0);
    n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL single_pulse: got %0b want 1", err_pulse); end
    n_checks++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", err_count); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL single_locked: got %0b want 1", locked); end
    step(1, 4'b0010, 0);
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL single_nopulse: got %0b want 0", err_pulse); end
    n_checks++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL single_hold: got %0d want 1", err_count); end
  endtask

  task automatic test_loss_of_lock();
    for (int i = 0; i < MISS_LIMIT; i++) begin
      step(1, 4'b0000, 0);
      n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL loss_pulse[%0d]: got %0b want 1", i, err_pulse); end
      if (i < MISS_LIMIT - 1) begin
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_early[%0d]: got %0b want 1", i, locked); end
      end
    end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL loss_locked: got %0b want 0", locked); end
    n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL loss_state: got %0d want 0", fsm_state); end
    n_checks++; if (err_count !== 16'd5) begin n_fail++; $display("FAIL loss_count: got %0d want 5", err_count); end
    send_lock_run();
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_relock: got %0b want 1", locked); end
  endtask

  task automatic test_idle();
    do_reset();
    repeat (3) begin
      step(1, 4'b0000, 0);
      n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL idle_hunt: got %0d want 0", fsm_state); end
    end
    send_lock_run();
    for (int i = 0; i < 5; i++) begin
      step(0, 4'($urandom_range(0, 15)), 0);
      n_checks++; if (locked !== 1'b1 || err_pulse !== 1'b0 || pred !== 4'b0001 || err_count !== 16'd0) begin
        n_fail++; $display("FAIL idle_gap[%0d]: got locked=%0b pulse=%0b pred=%b cnt=%0d want 1 0 0001 0",
                            i, locked, err_pulse, pred, err_count);
      end
    end
    step(1, 4'b0001, 0);
    n_checks++; if (err_pulse !== 1'b0 || pred !== 4'b0010) begin
      n_fail++; $display("FAIL idle_resume: got pulse=%0b pred=%b want 0 0010", err_pulse, pred);
    end
  endtask

  task automatic test_wrap_clr();
    int errs_seen;
    errs_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, m_pred, 0);
      if (err_pulse !== 1'b0) errs_seen++;
    end
    n_checks++; if (errs_seen != 0) begin n_fail++; $display("FAIL wrap_pulses: got %0d want 0", errs_seen); end
    n_checks++; if (err_count !== 16'd0 || locked !== 1'b1) begin
      n_fail++; $display("FAIL wrap_state: got cnt=%0d locked=%0b want 0 1", err_count, locked);
    end
    step(1, 4'b0000, 1);
    n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", err_count); end
    n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL clr_pulse: got %0b want 1", err_pulse); end
  endtask

  task automatic test_random();
    int p;
    bit v, c;
    logic [3:0] d, e;
    int r;
    do_reset();
    p = $urandom_range(0, 14);
    for (int cyc = 0; cyc < 600; cyc++) begin
      v = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 99);
      if (r < 85) begin d = seq_tab[p]; p = (p + 1) % 15; end
      else if (r < 93) d = 4'($urandom_range(0, 15));
      else if (r < 97) d = 4'd0;
      else begin p = $urandom_range(0, 14); d = seq_tab[p]; end
      c = ($urandom_range(0, 39) == 0);
      step(v, d, c);
      exp_q.push_back(m_pred);
      e = exp_q.pop_front();
      n_checks++;
      if (pred !== e || locked !== (m_mode == 2) || err_pulse !== m_pulse ||
          err_count !== 16'(m_errs) || fsm_state !== 2'(m_mode)) begin
        n_fail++;
        $display("FAIL random[%0d]: got pred=%b lk=%0b pl=%0b cnt=%0d st=%0d want pred=%b lk=%0b pl=%0b cnt=%0d st=%0d",
                 cyc, pred, locked, err_pulse, err_count, fsm_state, e, (m_mode == 2), m_pulse, m_errs, m_mode);
      end
    end
  endtask

  initial begin
    build_table();
    do_reset();
    test_reset();
    test_lock();
    test_single_error();
    test_loss_of_lock();
    test_idle();
    test_wrap_clr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
